seven_seg_decoder: RTL
======================

// Module: seven_seg_decoder
// PURPOSE
//  Receive side of the 2-digit multiplexed seven-segment bus (active-low gfedcba segments + digit select).
//  Recovers the displayed 8-bit hex value from segment/select waveforms for loopback self-test and for
//  snooping external display boards. Sits beside the display driver in gateware/utils.
// PARAMETERS
//  SETTLE_CYCLES   4     clk cycles after a synchronised sel edge before segments are sampled (>=1)
//  TIMEOUT_CYCLES  2048  clk cycles without a sel edge before signal_lost asserts (>= 2*SETTLE_CYCLES)
// PORTS
//  clk          in   1  system clock; single clock domain
//  rst          in   1  asynchronous, active-high reset
//  led          in   7  segment lines gfedcba, active-low, asynchronous to clk
//  sel          in   1  digit select: 0 = high nibble shown, 1 = low nibble shown; asynchronous
//  value        out  8  last accepted byte {high,low}
//  value_valid  out  1  one-cycle pulse when value updates
//  digit_err    out  1  one-cycle pulse when a sampled pattern is not a legal glyph
//  signal_lost  out  1  level; no sel edge for TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset: value=0, value_valid=0, digit_err=0, signal_lost=1, FSM=HUNT, all sync/holding regs 0.
//  - led and sel pass through 2-flop synchronisers; all logic below uses synchronised copies.
//  - Sel edge = change of synchronised sel vs its previous-cycle value.
//  - FSM: HUNT -> (sel edge) SETTLE; SETTLE counts SETTLE_CYCLES then -> CAPTURE (1 cycle: sample
//    segments, decode) -> WAIT_EDGE; WAIT_EDGE -> (sel edge) SETTLE. Edge during SETTLE restarts count.
//  - Decode: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//    8=0000000 9=0011000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000100 F=0001110.
//    7'b0000011 decodes to 4'hB, never 4'h6. Any other pattern is illegal.
//  - Illegal pattern: digit_err pulses in the cycle after CAPTURE; current frame discarded; no value update.
//  - Captured with sel=0 -> hi_hold; with sel=1 -> lo_hold. Frame completes on a legal low capture
//    immediately preceded by a legal high capture in the same frame.
//  - Frame complete: value <= {hi_hold,lo_hold}, value_valid pulses 1 cycle; latency = 1 cycle after CAPTURE.
//  - Out-of-order (low first after HUNT, two highs in a row) -> discard, no error pulse.
//  - Timeout counter clears on every sel edge; at TIMEOUT_CYCLES: signal_lost=1, FSM -> HUNT, holds cleared,
//    value retained. signal_lost deasserts on next sel edge.
//  - Timeout counter saturates; it does not wrap.
//  - rst mid-frame aborts the frame immediately; no pulse is emitted.
// CONFIGURATION
//  SEVEN_SEG_DEC_STABLE_EN defined:
//    - A decoded frame updates value only when it equals the previous decoded frame, i.e. two consecutive
//      identical frames are required.
//    - The first frame after reset/HUNT is only stored as the candidate.
//    - Illegal or discarded frames clear the candidate.
//  Undefined: every complete legal frame updates value and pulses value_valid, even if the value is unchanged.
// STRUCTURE
//  - seven_seg_pkg: segment glyph constants (SEG_0..SEG_F, active-low gfedcba) and FSM state enum
//    (HUNT, SETTLE, CAPTURE, WAIT_EDGE); shared with the display driver.
//  - Sub-module seven_seg_glyph_decode: combinational led[6:0] -> {legal, nibble[3:0]}.
//  - Synchronisers, FSM, counters and frame assembly live in the top module.
// TESTING
//  1. Drive 8'h3C via display waveform (sel period 1024 clk)
//     -> value=8'h3C, value_valid pulses once per frame, digit_err=0.
//  2. Display 8'h6B (low glyph 0000011, high 0000010)
//     -> value=8'h6B; verify 0000011 never yields 6.
//  3. Force led=7'b1111111 during one high-digit capture
//     -> digit_err one pulse, value unchanged, next clean frame resumes updates.
//  4. Hold sel static for 2048 clk -> signal_lost=1 and value retained;
//     restart toggling -> signal_lost=0 on first edge, value updates after next full frame.
//  5. Glitch sel for 2 clk inside SETTLE
//     -> settle restarts, no capture of transitional segments, no err pulse.
//  6. With SEVEN_SEG_DEC_STABLE_EN: frames 8'h12 then 8'h12
//     -> single value_valid on second frame; frames 8'h12,8'h34 -> no update.
//     Assert rst mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module      : seven_seg_pkg
// Description : Active-low gfedcba glyph constants and decoder FSM states,
//               shared between the seven-segment display driver and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0011000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000100;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SETTLE    = 2'd1,
        CAPTURE   = 2'd2,
        WAIT_EDGE = 2'd3
    } seg_state_e;

endpackage

`default_nettype wire

// File: rtl/seven_seg_glyph_decode.sv
// ============================================================================
// Module      : seven_seg_glyph_decode
// Description : Combinational active-low gfedcba pattern to {legal, nibble}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_led,
    output logic       o_legal,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_legal  = 1'b1;
        o_nibble = 4'h0;
        case (i_led)
            SEG_0:   o_nibble = 4'h0;
            SEG_1:   o_nibble = 4'h1;
            SEG_2:   o_nibble = 4'h2;
            SEG_3:   o_nibble = 4'h3;
            SEG_4:   o_nibble = 4'h4;
            SEG_5:   o_nibble = 4'h5;
            SEG_6:   o_nibble = 4'h6;
            SEG_7:   o_nibble = 4'h7;
            SEG_8:   o_nibble = 4'h8;
            SEG_9:   o_nibble = 4'h9;
            SEG_A:   o_nibble = 4'hA;
            // The lowercase b lacks segment a, so it differs from 6 by one line.
            SEG_B:   o_nibble = 4'hB;
            SEG_C:   o_nibble = 4'hC;
            SEG_D:   o_nibble = 4'hD;
            SEG_E:   o_nibble = 4'hE;
            SEG_F:   o_nibble = 4'hF;
            default: o_legal  = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seven_seg_decoder.sv
// ============================================================================
// Module      : seven_seg_decoder
// Description : Recovers the 8-bit value shown on a 2-digit multiplexed
//               seven-segment bus. Optional macro SEVEN_SEG_DEC_STABLE_EN
//               requires two identical consecutive frames per update.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_decoder
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] led,
    input  logic       sel,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       digit_err,
    output logic       signal_lost
);

    localparam int SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX  = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [6:0] led_meta_q, led_sync_q;
    logic       sel_meta_q, sel_sync_q, sel_prev_q;

    seg_state_e           state_q, state_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TIMEOUT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic                 signal_lost_q, signal_lost_d;
    logic [3:0]           hi_hold_q, hi_hold_d;
    logic [3:0]           lo_hold_q, lo_hold_d;
    logic                 hi_ok_q, hi_ok_d;
    logic [7:0]           value_q, value_d;
    logic                 value_valid_q, value_valid_d;
    logic                 digit_err_q, digit_err_d;
`ifdef SEVEN_SEG_DEC_STABLE_EN
    logic [7:0]           cand_q, cand_d;
    logic                 cand_valid_q, cand_valid_d;
`endif

    logic       w_sel_edge;
    logic       w_legal;
    logic [3:0] w_nibble;
    logic [7:0] w_frame;

    seven_seg_glyph_decode u_glyph (
        .i_led    (led_sync_q),
        .o_legal  (w_legal),
        .o_nibble (w_nibble)
    );

    assign w_sel_edge = sel_sync_q ^ sel_prev_q;
    assign w_frame    = {hi_hold_q, w_nibble};

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        signal_lost_d = signal_lost_q;
        hi_hold_d     = hi_hold_q;
        lo_hold_d     = lo_hold_q;
        hi_ok_d       = hi_ok_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        digit_err_d   = 1'b0;
`ifdef SEVEN_SEG_DEC_STABLE_EN
        cand_d        = cand_q;
        cand_valid_d  = cand_valid_q;
`endif

        case (state_q)
            HUNT, WAIT_EDGE: begin
                if (w_sel_edge) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (w_sel_edge) begin
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                settle_cnt_d = '0;
                // A fresh edge here means led_sync_q is already unsettled; resettle instead.
                if (w_sel_edge) begin
                    state_d = SETTLE;
                end else begin
                    state_d = WAIT_EDGE;
                    if (!w_legal) begin
                        digit_err_d = 1'b1;
                        hi_ok_d     = 1'b0;
`ifdef SEVEN_SEG_DEC_STABLE_EN
                        cand_valid_d = 1'b0;
`endif
                    end else if (!sel_sync_q) begin
                        hi_hold_d = w_nibble;
                        hi_ok_d   = !hi_ok_q;
`ifdef SEVEN_SEG_DEC_STABLE_EN
                        if (hi_ok_q) cand_valid_d = 1'b0;
`endif
                    end else begin
                        lo_hold_d = w_nibble;
                        hi_ok_d   = 1'b0;
                        if (hi_ok_q) begin
`ifdef SEVEN_SEG_DEC_STABLE_EN
                            if (cand_valid_q && (cand_q == w_frame)) begin
                                value_d       = w_frame;
                                value_valid_d = 1'b1;
                            end
                            cand_d       = w_frame;
                            cand_valid_d = 1'b1;
`else
                            value_d       = w_frame;
                            value_valid_d = 1'b1;
`endif
                        end else begin
`ifdef SEVEN_SEG_DEC_STABLE_EN
                            cand_valid_d = 1'b0;
`endif
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        // Saturating watchdog: fires once, then holds until the next sel edge.
        if (w_sel_edge) begin
            timeout_cnt_d = '0;
            signal_lost_d = 1'b0;
        end else if (timeout_cnt_q != TIMEOUT_MAX) begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
            if (timeout_cnt_q == TIMEOUT_LAST) begin
                signal_lost_d = 1'b1;
                state_d       = HUNT;
                hi_hold_d     = 4'h0;
                lo_hold_d     = 4'h0;
                hi_ok_d       = 1'b0;
                value_d       = value_q;
                value_valid_d = 1'b0;
                digit_err_d   = 1'b0;
`ifdef SEVEN_SEG_DEC_STABLE_EN
                cand_valid_d  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_meta_q    <= 7'h0;
            led_sync_q    <= 7'h0;
            sel_meta_q    <= 1'b0;
            sel_sync_q    <= 1'b0;
            sel_prev_q    <= 1'b0;
            state_q       <= HUNT;
            settle_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            signal_lost_q <= 1'b1;
            hi_hold_q     <= 4'h0;
            lo_hold_q     <= 4'h0;
            hi_ok_q       <= 1'b0;
            value_q       <= 8'h0;
            value_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
`ifdef SEVEN_SEG_DEC_STABLE_EN
            cand_q        <= 8'h0;
            cand_valid_q  <= 1'b0;
`endif
        end else begin
            led_meta_q    <= led;
            led_sync_q    <= led_meta_q;
            sel_meta_q    <= sel;
            sel_sync_q    <= sel_meta_q;
            sel_prev_q    <= sel_sync_q;
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            signal_lost_q <= signal_lost_d;
            hi_hold_q     <= hi_hold_d;
            lo_hold_q     <= lo_hold_d;
            hi_ok_q       <= hi_ok_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            digit_err_q   <= digit_err_d;
`ifdef SEVEN_SEG_DEC_STABLE_EN
            cand_q        <= cand_d;
            cand_valid_q  <= cand_valid_d;
`endif
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign digit_err   = digit_err_q;
    assign signal_lost = signal_lost_q;

endmodule

`default_nettype wire
